// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle MIPS controller (master) and its datapath/memory (slave).
interface multicycle_controller_if;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        memwrite;
    logic        iord;
    logic        irwrite;
    logic        pcwrite;
    logic [1:0]  pcsrc;
    logic        regwrite;
    logic        regdst;
    logic        memtoreg;
    logic        alusrca;
    logic [2:0]  alusrcb;
    logic [2:0]  alucontrol;
    logic        trap;
    logic        trap_cause;

    modport master (
        input  instr, zero, mem_ready,
        output mem_req, memwrite, iord, irwrite, pcwrite, pcsrc, regwrite,
               regdst, memtoreg, alusrca, alusrcb, alucontrol, trap, trap_cause
    );

    modport slave (
        output instr, zero, mem_ready,
        input  mem_req, memwrite, iord, irwrite, pcwrite, pcsrc, regwrite,
               regdst, memtoreg, alusrca, alusrcb, alucontrol, trap, trap_cause
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath with a memory wait timeout and sticky trap.
// Optional macro LUI_EN adds lui (op 001111) through an LUIEX state; otherwise lui traps as illegal.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);
    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_TRAP
`ifdef LUI_EN
        , S_LUIEX
`endif
    } state_t;

    state_t           r_state;
    logic [TMO_W-1:0] r_cnt;
    logic             r_trap;
    logic             r_trap_cause;

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_timeout;
    logic       w_unused;

    assign w_op      = bus.instr[31:26];
    assign w_funct   = bus.instr[5:0];
    assign w_timeout = (r_cnt == TMO_W'(MEM_TIMEOUT));
    assign w_unused  = ^bus.instr[25:6];

    // The counter is cleared by default, so any state change restarts it;
    // only a request state that keeps waiting advances it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_FETCH;
            r_cnt        <= '0;
            r_trap       <= 1'b0;
            r_trap_cause <= 1'b0;
        end else begin
            r_cnt <= '0;
            case (r_state)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        r_state      <= S_TRAP;
                        r_trap       <= 1'b1;
                        r_trap_cause <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    case (w_op)
                        6'b000000:            r_state <= S_EXEC;
                        6'b100011, 6'b101011: r_state <= S_MEMADR;
                        6'b000100:            r_state <= S_BRANCH;
                        6'b001001:            r_state <= S_ADDIEX;
                        6'b000010:            r_state <= S_JUMP;
`ifdef LUI_EN
                        6'b001111:            r_state <= S_LUIEX;
`endif
                        default: begin
                            r_state      <= S_TRAP;
                            r_trap       <= 1'b1;
                            r_trap_cause <= 1'b0;
                        end
                    endcase
                end
                S_EXEC:   r_state <= S_ALUWB;
                S_ALUWB:  r_state <= S_FETCH;
                S_MEMADR: r_state <= (w_op == 6'b100011) ? S_MEMRD : S_MEMWR;
                S_MEMRD: begin
                    if (bus.mem_ready) begin
                        r_state <= S_MEMWB;
                    end else if (w_timeout) begin
                        r_state      <= S_TRAP;
                        r_trap       <= 1'b1;
                        r_trap_cause <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_MEMWB:  r_state <= S_FETCH;
                S_MEMWR: begin
                    if (bus.mem_ready) begin
                        r_state <= S_FETCH;
                    end else if (w_timeout) begin
                        r_state      <= S_TRAP;
                        r_trap       <= 1'b1;
                        r_trap_cause <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_BRANCH: r_state <= S_FETCH;
                S_ADDIEX: r_state <= S_ADDIWB;
                S_ADDIWB: r_state <= S_FETCH;
                S_JUMP:   r_state <= S_FETCH;
`ifdef LUI_EN
                S_LUIEX:  r_state <= S_ADDIWB;
`endif
                S_TRAP:   r_state <= S_TRAP;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    logic       w_mem_req, w_memwrite, w_iord, w_irwrite, w_pcwrite;
    logic [1:0] w_pcsrc;
    logic       w_regwrite, w_regdst, w_memtoreg, w_alusrca;
    logic [2:0] w_alusrcb, w_alucontrol;

    always_comb begin
        w_mem_req    = 1'b0;
        w_memwrite   = 1'b0;
        w_iord       = 1'b0;
        w_irwrite    = 1'b0;
        w_pcwrite    = 1'b0;
        w_pcsrc      = 2'b00;
        w_regwrite   = 1'b0;
        w_regdst     = 1'b0;
        w_memtoreg   = 1'b0;
        w_alusrca    = 1'b0;
        w_alusrcb    = 3'b000;
        w_alucontrol = 3'b010;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                w_alusrcb = 3'b001;
                // A fetch completing while reset is still held must not commit PC/IR.
                if (bus.mem_ready && !reset) begin
                    w_irwrite = 1'b1;
                    w_pcwrite = 1'b1;
                end
            end
            S_DECODE: w_alusrcb = 3'b011;
            S_EXEC: begin
                w_alusrca = 1'b1;
                case (w_funct)
                    6'b100001: w_alucontrol = 3'b010;
                    6'b100011: w_alucontrol = 3'b110;
                    6'b100100: w_alucontrol = 3'b000;
                    6'b100101: w_alucontrol = 3'b001;
                    6'b101011: w_alucontrol = 3'b111;
                    default:   w_alucontrol = 3'b011;
                endcase
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_regdst   = 1'b1;
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 3'b010;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
            end
            S_MEMWR: begin
                w_mem_req  = 1'b1;
                w_memwrite = 1'b1;
                w_iord     = 1'b1;
            end
            S_BRANCH: begin
                w_alusrca    = 1'b1;
                w_alucontrol = 3'b110;
                w_pcsrc      = 2'b01;
                w_pcwrite    = bus.zero;
            end
            S_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 3'b010;
            end
            S_ADDIWB: w_regwrite = 1'b1;
            S_JUMP: begin
                w_pcwrite = 1'b1;
                w_pcsrc   = 2'b10;
            end
`ifdef LUI_EN
            S_LUIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 3'b100;
            end
`endif
            default: ;
        endcase
    end

    assign bus.mem_req    = w_mem_req;
    assign bus.memwrite   = w_memwrite;
    assign bus.iord       = w_iord;
    assign bus.irwrite    = w_irwrite;
    assign bus.pcwrite    = w_pcwrite;
    assign bus.pcsrc      = w_pcsrc;
    assign bus.regwrite   = w_regwrite;
    assign bus.regdst     = w_regdst;
    assign bus.memtoreg   = w_memtoreg;
    assign bus.alusrca    = w_alusrca;
    assign bus.alusrcb    = w_alusrcb;
    assign bus.alucontrol = w_alucontrol;
    assign bus.trap       = r_trap;
    assign bus.trap_cause = r_trap_cause;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control vectors go through a scoreboard queue.
module tb_multicycle_controller;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    logic [18:0] sb_q[$];
    string       tag_q[$];

    multicycle_controller_if bus();

    multicycle_controller #(.MEM_TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout: mem_req memwrite iord irwrite pcwrite pcsrc[2] regwrite regdst memtoreg
    //                alusrca alusrcb[3] alucontrol[3] trap trap_cause
    function automatic logic [18:0] ctl(input logic mreq, input logic mw, input logic io,
                                        input logic irw, input logic pcw, input logic [1:0] pcs,
                                        input logic rw, input logic rd, input logic m2r,
                                        input logic asa, input logic [2:0] asb, input logic [2:0] alu,
                                        input logic tr, input logic tc);
        return {mreq, mw, io, irw, pcw, pcs, rw, rd, m2r, asa, asb, alu, tr, tc};
    endfunction

    function automatic logic [18:0] f_fetch(input logic r);
        return ctl(1, 0, 0, r, r, 2'b00, 0, 0, 0, 0, 3'b001, 3'b010, 0, 0);
    endfunction
    function automatic logic [18:0] f_decode();
        return ctl(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b011, 3'b010, 0, 0);
    endfunction
    function automatic logic [18:0] f_exec(input logic [2:0] a);
        return ctl(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 3'b000, a, 0, 0);
    endfunction
    function automatic logic [18:0] f_aluwb();
        return ctl(0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 3'b000, 3'b010, 0, 0);
    endfunction
    function automatic logic [18:0] f_memadr();
        return ctl(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 3'b010, 3'b010, 0, 0);
    endfunction
    function automatic logic [18:0] f_memrd();
        return ctl(1, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 3'b010, 0, 0);
    endfunction
    function automatic logic [18:0] f_memwb();
        return ctl(0, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0, 3'b000, 3'b010, 0, 0);
    endfunction
    function automatic logic [18:0] f_memwr();
        return ctl(1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 3'b010, 0, 0);
    endfunction
    function automatic logic [18:0] f_branch(input logic z);
        return ctl(0, 0, 0, 0, z, 2'b01, 0, 0, 0, 1, 3'b000, 3'b110, 0, 0);
    endfunction
    function automatic logic [18:0] f_immex();
        return ctl(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 3'b010, 3'b010, 0, 0);
    endfunction
    function automatic logic [18:0] f_immwb();
        return ctl(0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 3'b000, 3'b010, 0, 0);
    endfunction
    function automatic logic [18:0] f_jump();
        return ctl(0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 3'b000, 3'b010, 0, 0);
    endfunction
    function automatic logic [18:0] f_trap(input logic c);
        return ctl(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 3'b010, 1, c);
    endfunction

    // Drive one cycle's inputs, queue its expectation, compare at the falling edge.
    task automatic cyc(input logic rdy, input logic z, input logic [18:0] exp, input string tag);
        logic [18:0] obs;
        logic [18:0] e;
        string       t;
        bus.mem_ready = rdy;
        bus.zero      = z;
        sb_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        obs = {bus.mem_req, bus.memwrite, bus.iord, bus.irwrite, bus.pcwrite, bus.pcsrc,
               bus.regwrite, bus.regdst, bus.memtoreg, bus.alusrca, bus.alusrcb,
               bus.alucontrol, bus.trap, bus.trap_cause};
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s observed=%05h expected=%05h", t, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.instr = 32'h0;
        bus.mem_ready = 1'b0;
        bus.zero = 1'b0;
        @(posedge clk);
        #1;
        cyc(0, 0, f_fetch(0), "reset_fetch");
        cyc(1, 0, f_fetch(0), "reset_no_commit");
        reset = 1'b0;

        bus.instr = 32'h00221821;
        cyc(1, 0, f_fetch(1), "addu_fetch");
        cyc(1, 0, f_decode(), "addu_decode");
        cyc(1, 0, f_exec(3'b010), "addu_exec");
        cyc(0, 0, f_aluwb(), "addu_aluwb");
        $display("[TB] addu %08h done, 4 cycles", bus.instr);

        bus.instr = 32'h8C850008;
        cyc(1, 0, f_fetch(1), "lw_fetch");
        cyc(0, 0, f_decode(), "lw_decode");
        cyc(0, 0, f_memadr(), "lw_memadr");
        for (int i = 0; i < 3; i++) cyc(0, 0, f_memrd(), "lw_memrd_wait");
        cyc(1, 0, f_memrd(), "lw_memrd_done");
        cyc(0, 0, f_memwb(), "lw_memwb");
        $display("[TB] lw %08h done, 8 cycles", bus.instr);

        bus.instr = 32'hAC850008;
        cyc(1, 0, f_fetch(1), "sw_fetch");
        cyc(0, 0, f_decode(), "sw_decode");
        cyc(0, 0, f_memadr(), "sw_memadr");
        cyc(1, 0, f_memwr(), "sw_memwr");
        $display("[TB] sw %08h done, 4 cycles", bus.instr);

        bus.instr = 32'h10220004;
        cyc(1, 1, f_fetch(1), "beq1_fetch");
        cyc(0, 1, f_decode(), "beq1_decode");
        cyc(0, 1, f_branch(1), "beq_taken");
        cyc(1, 0, f_fetch(1), "beq0_fetch");
        cyc(0, 0, f_decode(), "beq0_decode");
        cyc(0, 0, f_branch(0), "beq_not_taken");
        $display("[TB] beq %08h done twice, 3 cycles each", bus.instr);

        bus.instr = 32'h08000100;
        cyc(1, 0, f_fetch(1), "j_fetch");
        cyc(0, 0, f_decode(), "j_decode");
        cyc(0, 0, f_jump(), "j_jump");
        $display("[TB] j %08h done, 3 cycles", bus.instr);

        bus.instr = 32'h0022182B;
        cyc(1, 0, f_fetch(1), "sltu_fetch");
        cyc(0, 0, f_decode(), "sltu_decode");
        cyc(0, 0, f_exec(3'b111), "sltu_exec");
        cyc(0, 0, f_aluwb(), "sltu_aluwb");
        $display("[TB] sltu %08h done", bus.instr);

        bus.instr = 32'h00221823;
        cyc(1, 0, f_fetch(1), "subu_fetch");
        cyc(0, 0, f_decode(), "subu_decode");
        cyc(0, 0, f_exec(3'b110), "subu_exec");
        cyc(0, 0, f_aluwb(), "subu_aluwb");
        $display("[TB] subu %08h done", bus.instr);

        bus.instr = 32'h00221820;
        cyc(1, 0, f_fetch(1), "badfunct_fetch");
        cyc(0, 0, f_decode(), "badfunct_decode");
        cyc(0, 0, f_exec(3'b011), "badfunct_exec");
        cyc(0, 0, f_aluwb(), "badfunct_aluwb");
        $display("[TB] unknown funct %08h done", bus.instr);

        bus.instr = 32'h24220005;
        cyc(1, 0, f_fetch(1), "addiu_fetch");
        cyc(0, 0, f_decode(), "addiu_decode");
        cyc(0, 0, f_immex(), "addiu_ex");
        cyc(0, 0, f_immwb(), "addiu_wb");
        $display("[TB] addiu %08h done, 4 cycles", bus.instr);

        bus.instr = 32'hAC850008;
        cyc(1, 0, f_fetch(1), "swrst_fetch");
        cyc(0, 0, f_decode(), "swrst_decode");
        cyc(0, 0, f_memadr(), "swrst_memadr");
        cyc(0, 0, f_memwr(), "swrst_wait");
        reset = 1'b1;
        cyc(1, 0, f_memwr(), "swrst_reset_edge");
        cyc(1, 0, f_fetch(0), "swrst_after_reset");
        reset = 1'b0;
        $display("[TB] sw %08h aborted by reset", bus.instr);

        bus.instr = 32'hFC000000;
        cyc(1, 0, f_fetch(1), "illegal_fetch");
        cyc(1, 0, f_decode(), "illegal_decode");
        for (int i = 0; i < 3; i++) cyc(1, 1, f_trap(0), "illegal_trap_sticky");
        reset = 1'b1;
        cyc(0, 0, f_trap(0), "illegal_trap_reset_edge");
        reset = 1'b0;
        cyc(0, 0, f_fetch(0), "illegal_recovered");
        $display("[TB] illegal %08h trapped, cause 0", bus.instr);

        bus.instr = 32'h3C010012;
        cyc(1, 0, f_fetch(1), "lui_fetch");
        cyc(0, 0, f_decode(), "lui_decode");
`ifdef LUI_EN
        cyc(0, 0, ctl(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 3'b100, 3'b010, 0, 0), "lui_ex");
        cyc(0, 0, f_immwb(), "lui_wb");
`else
        cyc(0, 0, f_trap(0), "lui_trap");
        reset = 1'b1;
        cyc(0, 0, f_trap(0), "lui_trap_reset_edge");
        reset = 1'b0;
`endif
        $display("[TB] lui %08h done", bus.instr);

        bus.instr = 32'h00221821;
        for (int i = 0; i < 17; i++) cyc(0, 0, f_fetch(0), "tmo_wait");
        cyc(0, 0, f_trap(1), "tmo_trap");
        reset = 1'b1;
        cyc(0, 0, f_trap(1), "tmo_trap_reset_edge");
        reset = 1'b0;
        $display("[TB] fetch timeout trapped, cause 1");

        for (int i = 0; i < 16; i++) cyc(0, 0, f_fetch(0), "edge_wait");
        cyc(1, 0, f_fetch(1), "edge_ready_wins");
        cyc(0, 0, f_decode(), "edge_decode");
        cyc(0, 0, f_exec(3'b010), "edge_exec");
        cyc(0, 0, f_aluwb(), "edge_aluwb");
        cyc(0, 0, f_fetch(0), "edge_next_fetch");
        $display("[TB] fetch completed on timeout cycle, no trap");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
